// File: rtl/systolic_mm_ctrl_if.sv
// rtl/systolic_mm_ctrl_if.sv - control/result bus of the systolic tile sequencer
//   start, res_ready          : requester -> sequencer
//   busy, acc_clr, pe_en      : sequencer status and PE grid control
//   lane_valid, lane_k        : per-lane operand valid and buffer index (lane i at [i*KW +: KW])
//   res_valid, res_row, done  : result row handshake and completion pulse
interface systolic_mm_ctrl_if #(
  parameter int N = 4,
  parameter int K = 32
);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;

  logic            start;
  logic            busy;
  logic            acc_clr;
  logic            pe_en;
  logic [N-1:0]    lane_valid;
  logic [N*KW-1:0] lane_k;
  logic            res_valid;
  logic [RW-1:0]   res_row;
  logic            res_ready;
  logic            done;

  modport master (
    input  start, res_ready,
    output busy, acc_clr, pe_en, lane_valid, lane_k, res_valid, res_row, done
  );

  modport slave (
    output start, res_ready,
    input  busy, acc_clr, pe_en, lane_valid, lane_k, res_valid, res_row, done
  );
endinterface

// File: rtl/systolic_mm_ctrl.sv
// rtl/systolic_mm_ctrl.sv - start/done sequencer for one NxN systolic matmul tile
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : systolic_mm_ctrl_if.master (start/res_ready in, all control and result signals out)
module systolic_mm_ctrl #(
  parameter int N = 4,
  parameter int K = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  systolic_mm_ctrl_if.master    bus
);
  localparam int KW = (K > 1) ? $clog2(K) : 1;
  localparam int RW = (N > 1) ? $clog2(N) : 1;
  localparam int TW = ((K + 2*N - 1) > 1) ? $clog2(K + 2*N - 1) : 1;

  // Last compute step: K operands plus 2(N-1) cycles of skew/flush.
  localparam logic [TW-1:0] T_LAST   = TW'(K + 2*N - 3);
  localparam logic [RW-1:0] ROW_LAST = RW'(N - 1);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    COMPUTE,
    DRAIN,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   t_q, t_d;
  logic [RW-1:0]   row_q, row_d;
  logic            busy_q, busy_d;
  logic            acc_clr_q, acc_clr_d;
  logic            pe_en_q, pe_en_d;
  logic [N-1:0]    lane_valid_q, lane_valid_d;
  logic [N*KW-1:0] lane_k_q, lane_k_d;
  logic            res_valid_q, res_valid_d;
  logic            done_q, done_d;
  int              tv;

  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    row_d   = row_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLEAR;
      end
      CLEAR: begin
        state_d = COMPUTE;
        t_d     = '0;
      end
      COMPUTE: begin
        if (t_q == T_LAST) begin
          state_d = DRAIN;
          t_d     = '0;
        end else begin
          t_d = t_q + TW'(1);
        end
      end
      DRAIN: begin
        // res_valid is always high in DRAIN, so res_ready alone completes a handshake.
        if (bus.res_ready) begin
          if (row_q == ROW_LAST) begin
            state_d = DONE;
            row_d   = '0;
          end else begin
            row_d = row_q + RW'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Outputs are registered, so they are decoded from the next state / next step.
    busy_d      = (state_d == CLEAR) || (state_d == COMPUTE) || (state_d == DRAIN);
    acc_clr_d   = (state_d == CLEAR);
    pe_en_d     = (state_d == COMPUTE);
    res_valid_d = (state_d == DRAIN);
    done_d      = (state_d == DONE);

    // Lane i lags lane 0 by i steps: it carries operand t-i while i <= t <= i+K-1.
    tv           = int'(t_d);
    lane_valid_d = '0;
    lane_k_d     = '0;
    for (int i = 0; i < N; i++) begin
      if ((state_d == COMPUTE) && (tv >= i) && (tv <= i + K - 1)) begin
        lane_valid_d[i]         = 1'b1;
        lane_k_d[i*KW +: KW]    = KW'(t_d - TW'(i));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      t_q          <= '0;
      row_q        <= '0;
      busy_q       <= 1'b0;
      acc_clr_q    <= 1'b0;
      pe_en_q      <= 1'b0;
      lane_valid_q <= '0;
      lane_k_q     <= '0;
      res_valid_q  <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      t_q          <= t_d;
      row_q        <= row_d;
      busy_q       <= busy_d;
      acc_clr_q    <= acc_clr_d;
      pe_en_q      <= pe_en_d;
      lane_valid_q <= lane_valid_d;
      lane_k_q     <= lane_k_d;
      res_valid_q  <= res_valid_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.acc_clr    = acc_clr_q;
  assign bus.pe_en      = pe_en_q;
  assign bus.lane_valid = lane_valid_q;
  assign bus.lane_k     = lane_k_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_row    = row_q;
  assign bus.done       = done_q;
endmodule
